// File: rtl/types_pkg.sv
// Shared types and constants for the ALU operand loader.
package types_pkg;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        ISSUE  = 3'd3,
        DONE   = 3'd4
    } loader_state_t;

    typedef logic [3:0] aluop_t;

    localparam int KEY_ENTER  = 0;
    localparam int KEY_CANCEL = 1;
    localparam int WORD_W     = 32;

endpackage

// File: rtl/alu_operand_loader_key_debounce.sv
// One pushbutton: 2-FF synchronizer, stability counter and press pulse on a debounced 1->0.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic CLOCK_50,
    input  logic RST,
    input  logic key_n,
    output logic level,
    output logic press
);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;
    logic             settled;

    assign settled = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
        end
    end

    // Any cycle where the synchronized level matches the accepted one restarts the count.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (settled) begin
                cnt   <= '0;
                level <= sync_q2;
                press <= ~sync_q2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_operand_loader.sv
// Operand entry FSM: commits A, B and opcode from switches, then offers them with valid/ack.
//   state  | meaning
//   GET_A  | waiting for ENTER to capture operand A
//   GET_B  | waiting for ENTER to capture operand B
//   GET_OP | waiting for ENTER to capture opcode and raise op_valid
//   ISSUE  | transaction presented, keys ignored until op_ack
//   DONE   | transfer complete, ENTER or CANCEL restarts
import types_pkg::*;

module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              CLOCK_50,
    input  logic              RST,
    input  logic [3:0]        KEY,
    input  logic [17:0]       SW,
    output logic [WORD_W-1:0] port_a,
    output logic [WORD_W-1:0] port_b,
    output logic [3:0]        op,
    output logic              op_valid,
    input  logic              op_ack,
    output logic [4:0]        state_led
);

    loader_state_t     state;
    logic              enter_press;
    logic              cancel_press;
    logic              enter_level;
    logic              cancel_level;
    logic [WORD_W-1:0] sw_word;
    logic              unused_inputs;

    assign unused_inputs = ^{KEY[3:2], SW[17], enter_level, cancel_level};
    assign sw_word       = {{(WORD_W - 16){SW[16]}}, SW[15:0]};

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .CLOCK_50 (CLOCK_50),
        .RST      (RST),
        .key_n    (KEY[KEY_ENTER]),
        .level    (enter_level),
        .press    (enter_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
        .CLOCK_50 (CLOCK_50),
        .RST      (RST),
        .key_n    (KEY[KEY_CANCEL]),
        .level    (cancel_level),
        .press    (cancel_press)
    );

    // CANCEL outranks ENTER everywhere except ISSUE, where a presented transaction is never withdrawn.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state    <= GET_A;
            port_a   <= '0;
            port_b   <= '0;
            op       <= '0;
            op_valid <= 1'b0;
        end else begin
            case (state)
                GET_A: begin
                    if (cancel_press) begin
                        state <= GET_A;
                    end else if (enter_press) begin
                        port_a <= sw_word;
                        state  <= GET_B;
                    end
                end
                GET_B: begin
                    if (cancel_press) begin
                        state <= GET_A;
                    end else if (enter_press) begin
                        port_b <= sw_word;
                        state  <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (cancel_press) begin
                        state <= GET_A;
                    end else if (enter_press) begin
                        op       <= aluop_t'(SW[3:0]);
                        op_valid <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_ack) begin
                        op_valid <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (cancel_press || enter_press) begin
                        state <= GET_A;
                    end
                end
                default: state <= GET_A;
            endcase
        end
    end

    always_comb begin
        state_led = 5'b00000;
        case (state)
            GET_A:   state_led = 5'b00001;
            GET_B:   state_led = 5'b00010;
            GET_OP:  state_led = 5'b00100;
            ISSUE:   state_led = 5'b01000;
            DONE:    state_led = 5'b10000;
            default: state_led = 5'b00000;
        endcase
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader with a transaction-level reference model.
module tb_alu_operand_loader;

    logic        CLOCK_50 = 1'b0;
    logic        RST;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic        op_ack;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic [3:0]  op;
    logic        op_valid;
    logic [4:0]  state_led;

    int total = 0;
    int bad   = 0;

    // Reference model: state index follows the LED bit order (0 = GET_A .. 4 = DONE).
    int          m_state;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [3:0]  m_op;
    logic        m_valid;

    logic [73:0] dut_vec;
    assign dut_vec = {port_a, port_b, op, op_valid, state_led};

    always #5 CLOCK_50 = ~CLOCK_50;

    alu_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50  (CLOCK_50),
        .RST       (RST),
        .KEY       (KEY),
        .SW        (SW),
        .port_a    (port_a),
        .port_b    (port_b),
        .op        (op),
        .op_valid  (op_valid),
        .op_ack    (op_ack),
        .state_led (state_led)
    );

    function automatic logic [31:0] fill(input logic [17:0] s);
        return s[16] ? (32'hFFFF_0000 | {16'h0000, s[15:0]}) : {16'h0000, s[15:0]};
    endfunction

    function automatic logic [73:0] exp_vec();
        logic [4:0] led;
        led = 5'(1 << m_state);
        return {m_a, m_b, m_op, m_valid, led};
    endfunction

    task automatic model_reset();
        m_state = 0; m_a = '0; m_b = '0; m_op = '0; m_valid = 1'b0;
    endtask

    task automatic model_enter(input logic [17:0] s);
        case (m_state)
            0: begin m_a = fill(s); m_state = 1; end
            1: begin m_b = fill(s); m_state = 2; end
            2: begin m_op = s[3:0]; m_valid = 1'b1; m_state = 3; end
            4: m_state = 0;
            default: ;
        endcase
    endtask

    task automatic model_cancel();
        if (m_state != 3) m_state = 0;
    endtask

    task automatic model_ack();
        if (m_state == 3) begin m_valid = 1'b0; m_state = 4; end
    endtask

    // Full press/release cycle on ENTER and/or CANCEL, long enough to debounce both edges.
    task automatic press_key(input bit ent, input bit can);
        @(posedge CLOCK_50); #1;
        if (ent) KEY[0] = 1'b0;
        if (can) KEY[1] = 1'b0;
        repeat (8) @(posedge CLOCK_50);
        #1 KEY[1:0] = 2'b11;
        repeat (8) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic pulse_ack();
        @(posedge CLOCK_50); #1 op_ack = 1'b1;
        @(posedge CLOCK_50); #1 op_ack = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        RST = 1'b0; KEY = 4'hF; SW = '0; op_ack = 1'b0;
        #2 RST = 1'b1;
        #1;
        model_reset();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL reset_initial: got %h expected %h", dut_vec, exp_vec());
        end
        repeat (2) @(negedge CLOCK_50);
        RST = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL reset_release: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_transaction();
        SW = 18'h0_0005; press_key(1, 0); model_enter(SW);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL txn_a: got %h expected %h", dut_vec, exp_vec());
        end
        SW = 18'h1_FFFE; press_key(1, 0); model_enter(SW);
        total++;
        if (dut_vec !== exp_vec() || port_b !== 32'hFFFF_FFFE) begin
            bad++; $display("FAIL txn_b: got %h expected %h", dut_vec, exp_vec());
        end
        SW = 18'h0_0003; press_key(1, 0); model_enter(SW);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL txn_op: got %h expected %h", dut_vec, exp_vec());
        end
        pulse_ack(); model_ack();
        total++;
        if (dut_vec !== exp_vec() || state_led !== 5'b10000) begin
            bad++; $display("FAIL txn_ack: got %h expected %h", dut_vec, exp_vec());
        end
        press_key(1, 0); model_enter(SW);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL txn_restart: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_bounce();
        int changes;
        logic [4:0] prev_led;
        SW = 18'($urandom);
        changes = 0;
        prev_led = state_led;
        @(posedge CLOCK_50); #1 KEY[0] = 1'b0;
        repeat (2) @(posedge CLOCK_50); #1 KEY[0] = 1'b1;
        repeat (2) @(posedge CLOCK_50); #1 KEY[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            if (k == 7) model_enter(SW);
            if (state_led !== prev_led) changes++;
            prev_led = state_led;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL bounce_k%0d: got %h expected %h", k, dut_vec, exp_vec());
            end
        end
        @(posedge CLOCK_50); #1 KEY[0] = 1'b1;
        repeat (8) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        if (state_led !== prev_led) changes++;
        total++;
        if (changes !== 1 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL bounce_once: got changes=%0d vec=%h expected changes=1 vec=%h",
                            changes, dut_vec, exp_vec());
        end
    endtask

    task automatic test_held_key();
        press_key(0, 1); model_cancel();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL held_cancel: got %h expected %h", dut_vec, exp_vec());
        end
        SW = 18'($urandom);
        @(posedge CLOCK_50); #1 KEY[0] = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            if (k == 7) model_enter(SW);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL held_k%0d: got %h expected %h", k, dut_vec, exp_vec());
            end
        end
        @(posedge CLOCK_50); #1 KEY[0] = 1'b1;
        repeat (8) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL held_release: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_handshake_hold();
        SW = 18'($urandom); press_key(1, 0); model_enter(SW);
        SW = 18'($urandom); press_key(1, 0); model_enter(SW);
        total++;
        if (dut_vec !== exp_vec() || op_valid !== 1'b1) begin
            bad++; $display("FAIL hold_enter_issue: got %h expected %h", dut_vec, exp_vec());
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge CLOCK_50); #1;
            SW     = 18'($urandom);
            KEY[0] = (c >= 1 && c < 10) ? 1'b0 : 1'b1;
            KEY[1] = (c >= 8 && c < 18) ? 1'b0 : 1'b1;
            @(negedge CLOCK_50);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL hold_c%0d: got %h expected %h", c, dut_vec, exp_vec());
            end
        end
        repeat (8) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL hold_settle: got %h expected %h", dut_vec, exp_vec());
        end
        pulse_ack(); model_ack();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL hold_ack: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_cancel_priority();
        press_key(1, 0); model_enter(SW);
        SW = 18'($urandom); press_key(1, 0); model_enter(SW);
        SW = 18'($urandom); press_key(1, 0); model_enter(SW);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL prio_setup: got %h expected %h", dut_vec, exp_vec());
        end
        SW = {14'h0, ~m_op};
        press_key(1, 1); model_cancel();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL prio_cancel: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        SW = 18'($urandom); press_key(1, 0); model_enter(SW);
        SW = 18'($urandom); press_key(1, 0); model_enter(SW);
        SW = 18'($urandom);
        @(posedge CLOCK_50); #1;
        op_ack = 1'b1;
        KEY[0] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            if (k == 7) model_enter(SW);
            if (k == 8) model_ack();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL b2b_k%0d: got %h expected %h", k, dut_vec, exp_vec());
            end
        end
        @(posedge CLOCK_50); #1;
        op_ack = 1'b0;
        KEY[0] = 1'b1;
        repeat (8) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            SW = 18'($urandom);
            if (r < 5) begin
                press_key(1, 0); model_enter(SW);
            end else if (r < 7) begin
                press_key(0, 1); model_cancel();
            end else if (r < 8) begin
                press_key(1, 1); model_cancel();
            end else begin
                pulse_ack(); model_ack();
            end
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random_%0d_r%0d: got %h expected %h", i, r, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        press_key(0, 1); model_cancel();
        if (m_state == 3) begin pulse_ack(); model_ack(); press_key(0, 1); model_cancel(); end
        SW = 18'($urandom); press_key(1, 0); model_enter(SW);
        SW = 18'($urandom); press_key(1, 0); model_enter(SW);
        SW = 18'($urandom); press_key(1, 0); model_enter(SW);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL midreset_issue: got %h expected %h", dut_vec, exp_vec());
        end
        @(posedge CLOCK_50); #2 RST = 1'b1;
        #1;
        model_reset();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL midreset_async: got %h expected %h", dut_vec, exp_vec());
        end
        @(negedge CLOCK_50); RST = 1'b0;
        SW = 18'($urandom); press_key(1, 0); model_enter(SW);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL midreset_resume: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_transaction();
        test_bounce();
        test_held_key();
        test_handshake_hold();
        test_cancel_priority();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Front-end stage for the ALU FPGA test harness. Turns raw DE2 switches and pushbuttons into a clean, debounced operand/opcode transaction for the ALU. The user enters A, then B, then the opcode with an ENTER key. The block then presents `{port_a, port_b, op}` with a valid/ack handshake to the ALU/display stage. Replaces free-running switch sampling, so operands are stable and explicitly committed.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronized cycles before a key level is accepted (10 ms at 50 MHz).
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width.

Ports:
- `CLOCK_50`  in  1  sole clock, all flops posedge.
- `RST`  in  1  reset, asynchronous, active-high.
- `KEY`  in  4  raw pushbuttons, active-low. KEY[0] = ENTER, KEY[1] = CANCEL, KEY[3:2] unused.
- `SW`  in  18  switches. SW[15:0] is operand magnitude bits, SW[16] is the sign-fill bit, SW[3:0] is the opcode in GET_OP, SW[17] is ignored.
- `port_a`  out  32  committed operand A.
- `port_b`  out  32  committed operand B.
- `op`  out  4  committed ALU opcode.
- `op_valid`  out  1  transaction valid.
- `op_ack`  in  1  downstream accepted the transaction.
- `state_led`  out  5  one-hot state indicator, bit0 = GET_A … bit4 = DONE.

## Operation
- Each used key passes through a 2-FF synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count at 0.
  - A press pulse (1 cycle) fires on a debounced 1→0 transition. Release produces no pulse.
- FSM states are GET_A, GET_B, GET_OP, ISSUE, DONE.
  - GET_A + enter: `port_a <= {{16{SW[16]}}, SW[15:0]}`, go to GET_B.
  - GET_B + enter: `port_b <=` the same formula, go to GET_OP.
  - GET_OP + enter: `op <= SW[3:0]`, `op_valid <= 1`, go to ISSUE.
  - ISSUE: hold all outputs. When `op_ack` is 1 on a clock edge, `op_valid <= 0` and go to DONE.
  - DONE + enter: go to GET_A. Registers keep their values until overwritten.
- CANCEL in GET_A/GET_B/GET_OP/DONE: go to GET_A. Data registers are not cleared.
- CANCEL and ENTER are ignored in ISSUE, so a presented transaction is never withdrawn.
- Simultaneous ENTER and CANCEL pulses: CANCEL wins, except in ISSUE where both are ignored.
- `op_ack` outside ISSUE is ignored.
- `state_led` is a direct one-hot decode of the state register.

## Timing
- Reset values: `port_a = 0`, `port_b = 0`, `op = 0`, `op_valid = 0`, state GET_A, `state_led = 5'b00001`. Debounced levels reset to 1 (released), counters reset to 0.
- Press latency: from the raw KEY falling edge to the press pulse is 2 (sync) + DEBOUNCE_CYCLES cycles, ±1 for edge alignment.
- The state and data register update on the edge after the pulse cycle. SW is sampled on that same edge; there is no SW synchronizer and the switches are treated as quasi-static.
- `op_valid` rises on the same edge that enters ISSUE.
- Handshake: `op_valid` stays high and `port_a`/`port_b`/`op` stay stable until the first edge with `op_ack = 1`. `op_valid` is low in the following cycle.
  - If ack is already high when valid rises, the transfer completes on the next edge, so valid is high for exactly 1 cycle.
- Reset asserted mid-operation, including in ISSUE, immediately forces all reset values asynchronously. Release is synchronous to the next edge.
- A held key produces exactly one pulse. A new pulse requires release, debounce, then press again.

## Structure
- Shared package `types_pkg`:
  - `loader_state_t` enum (GET_A, GET_B, GET_OP, ISSUE, DONE).
  - `aluop_t` 4-bit opcode type.
  - Constants `KEY_ENTER = 0`, `KEY_CANCEL = 1`.
  - `WORD_W = 32`.
- Sub-module `key_debounce`: synchronizer, counter and press-pulse generator for one key. Parameter `DEBOUNCE_CYCLES`. Ports `CLOCK_50`, `RST`, `key_n`, `level`, `press`. Instantiated twice.
- Top: FSM plus operand/op/valid registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: assert RST mid-cycle → all outputs zero and `state_led = 00001` without waiting for a clock edge.
- Full transaction:
  - SW = 0x0_0005 then ENTER → `port_a = 0x00000005`.
  - SW = 0x1_FFFE then ENTER → `port_b = 0xFFFFFFFE`.
  - SW[3:0] = 0x3 then ENTER → `op = 3`, `op_valid = 1`.
  - `op_ack` pulse → `op_valid = 0`, `state_led = 10000`.
- Bounce: KEY[0] toggles 0/1/0 with gaps of 2 cycles, then held low 10 cycles → exactly one press pulse, 6 cycles after the last falling edge. The FSM advances once.
- Handshake hold: in ISSUE, hold `op_ack = 0` for 20 cycles while changing SW and pressing ENTER/CANCEL → outputs unchanged and `op_valid` stays 1. Ack then completes the transfer.
- Cancel priority: in GET_OP, press ENTER and CANCEL so their pulses coincide → state is GET_A, `op` unchanged, `op_valid = 0`.
- Held key: hold ENTER for 100 cycles in GET_A → only a GET_A→GET_B advance and no further transitions.
